// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: address geometry and the dump sequencer state
// encoding, used by the memory array, CPU side and the dump arbiter.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DEPTH  = 1 << DMEM_ADDR_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        SEND    = 3'd2,
        WAIT_TX = 3'd3,
        DONE    = 3'd4
    } dump_state_t;

endpackage

// File: rtl/dmem_dump_arbiter.sv
// Shares the single-port data memory between the CPU load/store port and a dump
// sequencer that streams a block of words to the UART; CPU has priority with a starve cap.
module dmem_dump_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [ADDR_W:0]   dump_count
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   count_q;
    logic [CNT_W-1:0]  starve_q;
    logic [DATA_W-1:0] tx_data_q;

    logic              start_ok;
    logic              in_fetch;
    logic              starved;
    logic              forced;
    logic              grant;
    logic              last_word;
    logic [ADDR_W-1:0] dump_addr;

    assign start_ok  = dump_start && (state_q == IDLE);
    assign in_fetch  = (state_q == FETCH);
    assign starved   = (starve_q == CNT_W'(STARVE_LIMIT));
    assign forced    = in_fetch && cpu_req && starved;
    assign grant     = in_fetch && (!cpu_req || starved);
    assign last_word = ((idx_q + (ADDR_W + 1)'(1)) == len_q);

    // Truncating add makes the dump wrap from the top word back to word 0.
    assign dump_addr = base_q + idx_q[ADDR_W-1:0];

    assign cpu_err   = cpu_req && (cpu_addr[31:ADDR_W] != '0);
    assign cpu_ready = cpu_req && !forced;
    assign cpu_rdata = cpu_err ? '0 : mem_rdata;
    assign mem_addr  = grant ? dump_addr : cpu_addr[ADDR_W-1:0];
    assign mem_we    = cpu_req && cpu_we && cpu_ready && !cpu_err;
    assign mem_wdata = cpu_wdata;

    assign tx_start   = (state_q == SEND);
    assign tx_data    = tx_data_q;
    assign dump_busy  = (state_q != IDLE);
    assign dump_done  = (state_q == DONE);
    assign dump_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = (dump_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (grant) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_d = last_word ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Dump bookkeeping; a stalled fetch counts up to the limit and then holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            tx_data_q <= '0;
        end else begin
            if (start_ok) begin
                base_q   <= dump_base;
                len_q    <= dump_len;
                idx_q    <= '0;
                count_q  <= '0;
                starve_q <= '0;
            end
            if (grant) begin
                tx_data_q <= mem_rdata;
                starve_q  <= '0;
            end else if (in_fetch && !starved) begin
                starve_q <= starve_q + CNT_W'(1);
            end
            if ((state_q == WAIT_TX) && tx_done) begin
                idx_q   <= idx_q + (ADDR_W + 1)'(1);
                count_q <= count_q + (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Directed self-checking bench for dmem_dump_arbiter with a behavioural memory
// (unwritten word i reads as 0xA0000000 | i) and a UART that answers 10 cycles later.
module tb_dmem_dump_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        dump_start = 1'b0;
    logic [9:0]  dump_base = '0;
    logic [10:0] dump_len = '0;
    logic        tx_start;
    logic [31:0] tx_data;
    logic        tx_done;
    logic        dump_busy;
    logic        dump_done;
    logic [10:0] dump_count;

    logic        uart_done = 1'b0;
    logic        manual_done = 1'b0;
    logic        uart_en = 1'b1;
    logic [31:0] wmem [0:1023];
    logic        written [0:1023];
    logic [31:0] cap [$];
    int          tx_cnt = 0;
    int          done_cnt = 0;
    int          n_pass = 0;
    int          n_total = 0;

    assign tx_done = uart_done | manual_done;

    always #5 clk = ~clk;

    dmem_dump_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .cpu_err    (cpu_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dump_start (dump_start),
        .dump_base  (dump_base),
        .dump_len   (dump_len),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .dump_count (dump_count)
    );

    assign mem_rdata = written[mem_addr] ? wmem[mem_addr] : (32'hA000_0000 | {22'd0, mem_addr});

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
        end else if (mem_we) begin
            wmem[mem_addr]    <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (tx_start) tx_cnt <= tx_cnt + 1;
        if (dump_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                cap.push_back(tx_data);
                if (uart_en) begin
                    repeat (10) @(negedge clk);
                    uart_done = 1'b1;
                    @(negedge clk);
                    uart_done = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_total++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    // Called at a falling edge; leaves dump_start high across exactly one rising edge.
    task automatic startDump(input logic [9:0] base, input logic [10:0] len);
        dump_base  = base;
        dump_len   = len;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
    endtask

    task automatic waitDone(input int prev, input string tag);
        int n = 0;
        while (done_cnt == prev && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 64'(done_cnt == prev), 64'd0);
    endtask

    task automatic checkCaptured(input string tag, input logic [31:0] exp_words [4], input int n);
        checkOutput({tag, "_count"}, 64'(cap.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_word%0d", tag, i),
                        (i < cap.size()) ? 64'(cap[i]) : 64'hBAD, 64'(exp_words[i]));
        end
    endtask

    initial begin
        logic [31:0] exp_words [4];
        int          tx_before;
        int          done_before;
        int          stall_cnt;
        int          stall_idx;
        int          n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_busy", 64'(dump_busy), 64'd0);
        checkOutput("rst_tx_start", 64'(tx_start), 64'd0);
        checkOutput("rst_tx_data", 64'(tx_data), 64'd0);
        checkOutput("rst_dump_done", 64'(dump_done), 64'd0);
        checkOutput("rst_dump_count", 64'(dump_count), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we), 64'd0);

        // CPU write then read of word 5, both completing in the same cycle.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
        #1;
        checkOutput("wr5_ready", 64'(cpu_ready), 64'd1);
        checkOutput("wr5_mem_we", 64'(mem_we), 64'd1);
        checkOutput("wr5_mem_addr", 64'(mem_addr), 64'd5);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'd5, 32'd0);
        #1;
        checkOutput("rd5_ready", 64'(cpu_ready), 64'd1);
        checkOutput("rd5_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);

        // Out-of-range write is acknowledged with an error and never reaches memory.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'd1024, 32'h1111_2222);
        #1;
        checkOutput("oor_err", 64'(cpu_err), 64'd1);
        checkOutput("oor_ready", 64'(cpu_ready), 64'd1);
        checkOutput("oor_mem_we", 64'(mem_we), 64'd0);
        checkOutput("oor_rdata", 64'(cpu_rdata), 64'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
        #1;
        checkOutput("rd0_rdata", 64'(cpu_rdata), 64'hA000_0000);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        // Plain dump of words 2..4 with an idle CPU.
        cap.delete();
        tx_before   = tx_cnt;
        done_before = done_cnt;
        startDump(10'd2, 11'd3);
        waitDone(done_before, "d1_timeout");
        repeat (2) @(negedge clk);
        #1;
        exp_words = '{32'hA000_0002, 32'hA000_0003, 32'hA000_0004, 32'h0};
        checkCaptured("d1", exp_words, 3);
        checkOutput("d1_tx_starts", 64'(tx_cnt - tx_before), 64'd3);
        checkOutput("d1_done_pulses", 64'(done_cnt - done_before), 64'd1);
        checkOutput("d1_dump_count", 64'(dump_count), 64'd3);
        checkOutput("d1_busy", 64'(dump_busy), 64'd0);

        // Wrapping dump; a second start while busy must not restart or clear anything.
        cap.delete();
        tx_before   = tx_cnt;
        done_before = done_cnt;
        startDump(10'd1022, 11'd4);
        repeat (5) @(negedge clk);
        startDump(10'd0, 11'd1);
        waitDone(done_before, "d2_timeout");
        repeat (2) @(negedge clk);
        #1;
        exp_words = '{32'hA000_03FE, 32'hA000_03FF, 32'hA000_0000, 32'hA000_0001};
        checkCaptured("d2", exp_words, 4);
        checkOutput("d2_tx_starts", 64'(tx_cnt - tx_before), 64'd4);
        checkOutput("d2_done_pulses", 64'(done_cnt - done_before), 64'd1);
        checkOutput("d2_dump_count", 64'(dump_count), 64'd4);

        // CPU hammers word 7 throughout FETCH: 8 stalls, then one forced dump grant.
        cap.delete();
        done_before = done_cnt;
        stall_cnt   = 0;
        stall_idx   = -1;
        applyStimulus(1'b1, 1'b1, 32'd7, 32'h1234_5678);
        startDump(10'd10, 11'd1);
        for (int i = 0; i < 15; i++) begin
            #1;
            if (!cpu_ready) begin
                stall_cnt++;
                stall_idx = i;
                checkOutput("st_forced_mem_we", 64'(mem_we), 64'd0);
                checkOutput("st_forced_addr", 64'(mem_addr), 64'd10);
            end
            @(negedge clk);
        end
        checkOutput("st_stall_cycles", 64'(stall_cnt), 64'd1);
        checkOutput("st_stall_index", 64'(stall_idx), 64'd8);
        waitDone(done_before, "st_timeout");
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("st_word", (cap.size() > 0) ? 64'(cap[0]) : 64'hBAD, 64'hA000_000A);

        // Zero-length dump goes straight to DONE with no UART traffic.
        repeat (2) @(negedge clk);
        tx_before   = tx_cnt;
        done_before = done_cnt;
        startDump(10'd3, 11'd0);
        #1;
        checkOutput("z_done_pulse", 64'(dump_done), 64'd1);
        @(negedge clk);
        #1;
        checkOutput("z_done_cleared", 64'(dump_done), 64'd0);
        checkOutput("z_busy", 64'(dump_busy), 64'd0);
        checkOutput("z_tx_starts", 64'(tx_cnt - tx_before), 64'd0);
        checkOutput("z_done_pulses", 64'(done_cnt - done_before), 64'd1);
        checkOutput("z_dump_count", 64'(dump_count), 64'd0);

        // Reset while waiting on the UART aborts silently; a late tx_done is ignored.
        uart_en = 1'b0;
        tx_before   = tx_cnt;
        done_before = done_cnt;
        startDump(10'd3, 11'd2);
        n = 0;
        while (tx_cnt == tx_before && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("rw_tx_seen", 64'(tx_cnt - tx_before), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rw_busy_before", 64'(dump_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rw_busy_after", 64'(dump_busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("rw_tx_starts", 64'(tx_cnt - tx_before), 64'd1);
        checkOutput("rw_done_pulses", 64'(done_cnt - done_before), 64'd0);
        checkOutput("rw_busy_late", 64'(dump_busy), 64'd0);
        checkOutput("rw_dump_count", 64'(dump_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
